mem_cmd_sequencer: RTL and testbench

Sits between the switch/key front-end (the block producing mode, address, data and ioDone) and the memory controller. It latches one user command (write, read or clear), sequences it onto the memory request/acknowledge interface, returns read data, and reports completion. Clear mode sweeps an address range, writing a fixed fill value to every word. It also drives the ready flag the front-end uses as its memDone input.

---
 rtl/mem_cmd_sequencer_if.sv | 22 ++
 rtl/mem_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cmd_sequencer_if.sv
// Memory request/acknowledge bus between the command sequencer (master) and the memory controller (slave).
interface mem_cmd_sequencer_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// Latches one front-end command (write/read/clear sweep) and sequences it onto the memory req/ack bus.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_cmd_sequencer #(
    parameter int                ADDR_W         = 25,
    parameter int                DATA_W         = 16,
    parameter logic [ADDR_W-1:0] CLEAR_LAST     = 25'h1FFFFFF,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = 16'h0000,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              io_req,
    input  logic [1:0]        io_mode,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic              io_abort,
    output logic              io_ready,
    output logic              io_done,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_rvalid,
    output logic              io_err,
    mem_cmd_sequencer_if.master mem
);

    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        CLR_ISSUE,
        CLR_WAIT,
        DONE
    } stateT;

    stateT             state;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [ADDR_W-1:0] pointer;
    logic              abortPending;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] waitCnt;
`else
    logic unusedTimeout;
    assign unusedTimeout = (TIMEOUT_CYCLES != 0);
    assign io_err        = 1'b0;
`endif

    assign mem.mem_req   = memReq;
    assign mem.mem_we    = memWe;
    assign mem.mem_addr  = memAddr;
    assign mem.mem_wdata = memWdata;

    // Read/write requests go out on the edge that accepts io_req, so ISSUE already has mem_req high
    // and an ack there counts; clear words use CLR_ISSUE as the req-low gap between words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            io_ready     <= 1'b1;
            io_done      <= 1'b0;
            io_rvalid    <= 1'b0;
            io_rdata     <= '0;
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            memAddr      <= '0;
            memWdata     <= '0;
            pointer      <= '0;
            abortPending <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            io_err       <= 1'b0;
            waitCnt      <= '0;
`endif
        end else begin
            io_done   <= 1'b0;
            io_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (io_req) begin
                        if (io_mode == MODE_WRITE || io_mode == MODE_READ) begin
                            state    <= ISSUE;
                            io_ready <= 1'b0;
                            memReq   <= 1'b1;
                            memWe    <= (io_mode == MODE_WRITE);
                            memAddr  <= io_addr;
                            memWdata <= io_wdata;
`ifdef MEM_TIMEOUT_EN
                            waitCnt  <= '0;
`endif
                        end else if (io_mode == MODE_CLEAR) begin
                            state        <= CLR_ISSUE;
                            io_ready     <= 1'b0;
                            pointer      <= '0;
                            abortPending <= 1'b0;
                        end
                    end
                end
                ISSUE, WAIT_ACK: begin
                    if (mem.mem_ack) begin
                        memReq    <= 1'b0;
                        state     <= DONE;
                        io_done   <= 1'b1;
                        io_rvalid <= !memWe;
                        if (!memWe) begin
                            io_rdata <= mem.mem_rdata;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (waitCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        memReq  <= 1'b0;
                        io_err  <= 1'b1;
                        state   <= DONE;
                        io_done <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                        state   <= WAIT_ACK;
`else
                    end else begin
                        state <= WAIT_ACK;
`endif
                    end
                end
                CLR_ISSUE: begin
                    memReq   <= 1'b1;
                    memWe    <= 1'b1;
                    memAddr  <= pointer;
                    memWdata <= CLEAR_VALUE;
                    state    <= CLR_WAIT;
`ifdef MEM_TIMEOUT_EN
                    waitCnt  <= '0;
`endif
                    if (io_abort) begin
                        abortPending <= 1'b1;
                    end
                end
                CLR_WAIT: begin
                    if (io_abort) begin
                        abortPending <= 1'b1;
                    end
                    // Last-address test comes before the increment so an all-ones limit never wraps.
                    if (mem.mem_ack) begin
                        memReq <= 1'b0;
                        if (pointer == CLEAR_LAST || abortPending || io_abort) begin
                            state   <= DONE;
                            io_done <= 1'b1;
                        end else begin
                            pointer <= pointer + 1'b1;
                            state   <= CLR_ISSUE;
                        end
`ifdef MEM_TIMEOUT_EN
                    end else if (waitCnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        memReq  <= 1'b0;
                        io_err  <= 1'b1;
                        state   <= DONE;
                        io_done <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    io_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    io_ready <= 1'b1;
                    memReq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Randomized self-checking bench: a memory responder with random ack latency and a spec-level
// command model (expected transfer list + reference memory) checked at every io_done.
module tb_mem_cmd_sequencer;

    localparam int          ADDR_W   = 25;
    localparam int          DATA_W   = 16;
    localparam logic [24:0] CLR_LAST = 25'hF;
    localparam int          TIMEOUT  = 4;
    localparam int          MAX_WAIT = 400;

    typedef struct packed {
        logic        we;
        logic [24:0] addr;
        logic [15:0] data;
    } xferT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_req;
    logic [1:0]  io_mode;
    logic [24:0] io_addr;
    logic [15:0] io_wdata;
    logic        io_abort;
    logic        io_ready;
    logic        io_done;
    logic [15:0] io_rdata;
    logic        io_rvalid;
    logic        io_err;

    int checks = 0;
    int errors = 0;

    xferT        obsQ[$];
    xferT        expQ[$];
    logic [15:0] refMem [logic [24:0]];
    logic [15:0] memModel [logic [24:0]];
    logic [15:0] lastRead = 16'h0000;
    logic        expErr = 1'b0;

    int   abortAddr = -1;
    bit   abortSent = 1'b0;
    bit   noAck = 1'b0;
    int   reqCycles = 0;

    always #5 clk = ~clk;

    mem_cmd_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memIf ();

    mem_cmd_sequencer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CLEAR_LAST(CLR_LAST),
        .CLEAR_VALUE(16'h0000),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_req(io_req),
        .io_mode(io_mode),
        .io_addr(io_addr),
        .io_wdata(io_wdata),
        .io_abort(io_abort),
        .io_ready(io_ready),
        .io_done(io_done),
        .io_rdata(io_rdata),
        .io_rvalid(io_rvalid),
        .io_err(io_err),
        .mem(memIf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] refRead(input logic [24:0] a);
        return refMem.exists(a) ? refMem[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] memRead(input logic [24:0] a);
        return memModel.exists(a) ? memModel[a] : 16'h0000;
    endfunction

    function automatic logic [24:0] randAddr();
        logic [24:0] a;
        a = 25'($urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) a = a | 25'h1000000;
        return a;
    endfunction

    // Memory responder: random ack latency, spurious acks while idle, optional abort injection.
    initial begin
        int          reqCnt = 0;
        int          ackTarget = 0;
        bit          prevReq = 1'b0;
        logic        prevWe = 1'b0;
        logic [24:0] prevAddr = '0;
        logic [15:0] prevData = '0;
        memIf.mem_ack   = 1'b0;
        memIf.mem_rdata = 16'h0000;
        io_abort        = 1'b0;
        forever begin
            @(negedge clk);
            memIf.mem_ack = 1'b0;
            io_abort      = 1'b0;
            if (rst_n !== 1'b1) begin
                reqCnt  = 0;
                prevReq = 1'b0;
            end else if (memIf.mem_req === 1'b1) begin
                reqCycles++;
                if (prevReq) begin
                    checkOutput("req_stable", {memIf.mem_we, memIf.mem_addr, memIf.mem_wdata[5:0]},
                                {prevWe, prevAddr, prevData[5:0]});
                end
                prevReq  = 1'b1;
                prevWe   = memIf.mem_we;
                prevAddr = memIf.mem_addr;
                prevData = memIf.mem_wdata;
                if (!noAck) begin
                    if (abortAddr >= 0 && !abortSent && memIf.mem_addr == 25'(abortAddr)) begin
                        io_abort  = 1'b1;
                        abortSent = 1'b1;
                    end else if (reqCnt >= ackTarget) begin
                        memIf.mem_ack = 1'b1;
                        if (memIf.mem_we) begin
                            memModel[memIf.mem_addr] = memIf.mem_wdata;
                        end else begin
                            memIf.mem_rdata = memRead(memIf.mem_addr);
                        end
                        obsQ.push_back('{memIf.mem_we, memIf.mem_addr, memIf.mem_wdata});
                        reqCnt    = 0;
                        ackTarget = $urandom_range(0, 2);
                    end else begin
                        reqCnt++;
                    end
                end
            end else begin
                reqCnt  = 0;
                prevReq = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    memIf.mem_ack   = 1'b1;
                    memIf.mem_rdata = 16'($urandom);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] mode, input logic [24:0] addr, input logic [15:0] wdata,
                                 input int abortAt, input bit busyPokes);
        int  cycles;
        int  last;
        bit  isRead;
        isRead = (mode == 2'b01);
        expQ.delete();
        if (!noAck) begin
            if (mode == 2'b10) expQ.push_back('{1'b1, addr, wdata});
            if (mode == 2'b01) expQ.push_back('{1'b0, addr, 16'h0000});
            if (mode == 2'b00) begin
                last = (abortAt >= 0) ? abortAt : int'(CLR_LAST);
                for (int a = 0; a <= last; a++) expQ.push_back('{1'b1, 25'(a), 16'h0000});
            end
        end
        obsQ.delete();
        reqCycles = 0;
        abortAddr = (mode == 2'b00) ? abortAt : -1;
        abortSent = 1'b0;

        @(negedge clk);
        io_mode  = mode;
        io_addr  = addr;
        io_wdata = wdata;
        io_req   = 1'b1;
        @(negedge clk);
        io_req = 1'b0;

        if (mode == 2'b11) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("noop_ready", io_ready, 1);
                checkOutput("noop_done", io_done, 0);
                checkOutput("noop_req", memIf.mem_req, 0);
                @(negedge clk);
            end
            checkOutput("noop_xfers", obsQ.size(), 0);
            return;
        end

        if (mode != 2'b00) checkOutput("req_latency", memIf.mem_req, 1);

        cycles = 0;
        while (io_done !== 1'b1 && cycles < MAX_WAIT) begin
            checkOutput("ready_busy", io_ready, 0);
            if (busyPokes && $urandom_range(0, 2) == 0) begin
                io_mode  = 2'($urandom_range(0, 3));
                io_addr  = randAddr();
                io_req   = 1'b1;
            end
            @(negedge clk);
            io_req = 1'b0;
            cycles++;
        end
        if (cycles >= MAX_WAIT) begin
            checkOutput("done_wait", 0, 1);
            return;
        end

        checkOutput("rvalid", io_rvalid, (isRead && !noAck) ? 1 : 0);
        if (isRead && !noAck) lastRead = refRead(addr);
        checkOutput("rdata", io_rdata, lastRead);
        checkOutput("err", io_err, expErr);
        if (noAck) checkOutput("timeout_req_cycles", reqCycles, TIMEOUT);
        checkOutput("xfer_count", obsQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
            checkOutput("xfer_we", obsQ[i].we, expQ[i].we);
            checkOutput("xfer_addr", obsQ[i].addr, expQ[i].addr);
            if (expQ[i].we) checkOutput("xfer_data", obsQ[i].data, expQ[i].data);
        end
        foreach (expQ[i]) if (expQ[i].we) refMem[expQ[i].addr] = expQ[i].data;

        @(negedge clk);
        checkOutput("done_pulse", io_done, 0);
        checkOutput("rvalid_pulse", io_rvalid, 0);
        checkOutput("ready_after", io_ready, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        io_req   = 1'b0;
        io_mode  = 2'b11;
        io_addr  = '0;
        io_wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", io_ready, 1);
        checkOutput("rst_done", io_done, 0);
        checkOutput("rst_req", memIf.mem_req, 0);
        checkOutput("rst_we", memIf.mem_we, 0);
        checkOutput("rst_addr", memIf.mem_addr, 0);
        checkOutput("rst_rdata", io_rdata, 0);
        checkOutput("rst_err", io_err, 0);
        rst_n = 1'b1;

        applyStimulus(2'b10, 25'h0001234, 16'hBEEF, -1, 1'b0);
        applyStimulus(2'b10, 25'h1000000, 16'hA5A5, -1, 1'b0);
        applyStimulus(2'b01, 25'h1000000, 16'h0000, -1, 1'b1);
        applyStimulus(2'b01, 25'h0001234, 16'h0000, -1, 1'b1);
        applyStimulus(2'b11, 25'h0000005, 16'h1111, -1, 1'b0);
        applyStimulus(2'b10, 25'h0000003, 16'h3333, -1, 1'b0);
        applyStimulus(2'b00, 25'h0000000, 16'h0000, 3, 1'b0);
        applyStimulus(2'b01, 25'h0000003, 16'h0000, -1, 1'b0);
        applyStimulus(2'b00, 25'h0000000, 16'h0000, -1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] m;
            int         ab;
            m  = 2'($urandom_range(0, 3));
            ab = -1;
            if (m == 2'b00 && $urandom_range(0, 1) == 1) ab = $urandom_range(0, int'(CLR_LAST));
            applyStimulus(m, randAddr(), 16'($urandom), ab, 1'b1);
        end

        // Reset in the middle of a sweep; a full clear afterwards resynchronises the model.
        @(negedge clk);
        io_mode = 2'b00;
        io_req  = 1'b1;
        @(negedge clk);
        io_req = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_req", memIf.mem_req, 0);
        checkOutput("midrst_ready", io_ready, 1);
        checkOutput("midrst_rdata", io_rdata, 0);
        lastRead = 16'h0000;
        rst_n = 1'b1;
        applyStimulus(2'b00, 25'h0000000, 16'h0000, -1, 1'b0);
        applyStimulus(2'b01, 25'h0000007, 16'h0000, -1, 1'b0);

`ifdef MEM_TIMEOUT_EN
        noAck = 1'b1;
        expErr = 1'b1;
        applyStimulus(2'b10, 25'h0000020, 16'hDEAD, -1, 1'b0);
        noAck = 1'b0;
        applyStimulus(2'b10, 25'h0000021, 16'hCAFE, -1, 1'b0);
        applyStimulus(2'b01, 25'h0000021, 16'h0000, -1, 1'b0);
`endif

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("final_rst_err", io_err, 0);
        checkOutput("final_rst_ready", io_ready, 1);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
